conv_window_gen_3x3: RTL and testbench

- Streaming 3x3 sliding-window generator that sits directly upstream of the 3x3 6-bit PIM convolution stage.
- Accepts a raster-order pixel stream, one 6-bit pixel per handshake.
- Buffers two image lines and emits every valid (unpadded) 3x3 neighbourhood as nine parallel 6-bit words, matching the conv stage's in_data_0..8 ordering.
- Provides valid/ready backpressure and frame-boundary signalling.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_window_gen_3x3_if.sv | 41 ++++
 rtl/line_delay.sv | 31 +++
 rtl/conv_window_gen_3x3.sv | 157 +++++++++++++++
 tb/tb_conv_window_gen_3x3.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution front end.
// Used by the window generator, its interface and the testbench.
package conv_pkg;

    localparam int PIX_W       = 6;
    localparam int KERNEL_DIM  = 3;
    localparam int KERNEL_TAPS = 9;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        DRAIN
    } fsm_state_t;

    function automatic int win_count(input int h, input int w);
        return (h - 2) * (w - 2);
    endfunction

endpackage

// File: rtl/conv_window_gen_3x3_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen_3x3.
// slave is the generator side, master is the producer/consumer side.
interface conv_window_gen_3x3_if
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  win_valid;
    logic                  win_ready;
    logic                  win_last;
    logic [DATA_WIDTH-1:0] win_data_0;
    logic [DATA_WIDTH-1:0] win_data_1;
    logic [DATA_WIDTH-1:0] win_data_2;
    logic [DATA_WIDTH-1:0] win_data_3;
    logic [DATA_WIDTH-1:0] win_data_4;
    logic [DATA_WIDTH-1:0] win_data_5;
    logic [DATA_WIDTH-1:0] win_data_6;
    logic [DATA_WIDTH-1:0] win_data_7;
    logic [DATA_WIDTH-1:0] win_data_8;

    modport slave (
        input  in_valid, in_data, win_ready,
        output in_ready, win_valid, win_last,
        output win_data_0, win_data_1, win_data_2,
        output win_data_3, win_data_4, win_data_5,
        output win_data_6, win_data_7, win_data_8
    );

    modport master (
        output in_valid, in_data, win_ready,
        input  in_ready, win_valid, win_last,
        input  win_data_0, win_data_1, win_data_2,
        input  win_data_3, win_data_4, win_data_5,
        input  win_data_6, win_data_7, win_data_8
    );

endinterface

// File: rtl/line_delay.sv
// One image line of delay; advances only when shift_en is high.
// dout is the sample written DEPTH shifts ago.
module line_delay #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (shift_en) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign dout = r_mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen_3x3.sv
// Streaming 3x3 window generator feeding the PIM convolution stage.
// Two line delays plus a 3x3 shift array; one window per accept.
module conv_window_gen_3x3
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    conv_window_gen_3x3_if.slave bus
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam int K = KERNEL_DIM - 1;

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    fsm_state_t            r_state;
    fsm_state_t            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_win [KERNEL_DIM][KERNEL_DIM];
    logic                  r_win_valid;
    logic                  r_win_last;

    logic                  w_acc;
    logic                  w_col_end;
    logic                  w_row_end;
    logic                  w_frame_end;
    logic                  w_qual;
    logic [DATA_WIDTH-1:0] w_line0;
    logic [DATA_WIDTH-1:0] w_line1;

    // Ready depends only on the output register, never on in_valid.
    assign bus.in_ready = !r_win_valid | bus.win_ready;
    assign w_acc        = bus.in_valid & bus.in_ready;
    assign w_col_end    = (r_col == COL_LAST);
    assign w_row_end    = (r_row == ROW_LAST);
    assign w_frame_end  = w_col_end & w_row_end;
    assign w_qual       = w_acc & (r_state == RUN)
                        & (r_row >= RW'(2))
                        & (r_col >= CW'(2));

    line_delay #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (IMG_WIDTH)
    ) u_line0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_en(w_acc),
        .din     (bus.in_data),
        .dout    (w_line0)
    );

    line_delay #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (IMG_WIDTH)
    ) u_line1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_en(w_acc),
        .din     (w_line0),
        .dout    (w_line1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            FILL: begin
                if (w_acc && r_row == RW'(1) && w_col_end) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_acc && w_frame_end) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_win_valid && bus.win_ready) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KERNEL_DIM; i++) begin
                for (int j = 0; j < KERNEL_DIM; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (w_acc) begin
            for (int i = 0; i < KERNEL_DIM; i++) begin
                for (int j = 0; j < K; j++) begin
                    r_win[i][j] <= r_win[i][j+1];
                end
            end
            r_win[0][K] <= w_line1;
            r_win[1][K] <= w_line0;
            r_win[2][K] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else if (w_acc) begin
            r_win_valid <= w_qual;
            r_win_last  <= w_qual & w_frame_end;
        end else if (bus.win_ready) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end
    end

    assign bus.win_valid  = r_win_valid;
    assign bus.win_last   = r_win_last;
    assign bus.win_data_0 = r_win[0][0];
    assign bus.win_data_1 = r_win[0][1];
    assign bus.win_data_2 = r_win[0][2];
    assign bus.win_data_3 = r_win[1][0];
    assign bus.win_data_4 = r_win[1][1];
    assign bus.win_data_5 = r_win[1][2];
    assign bus.win_data_6 = r_win[2][0];
    assign bus.win_data_7 = r_win[2][1];
    assign bus.win_data_8 = r_win[2][2];

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Directed bench for conv_window_gen_3x3 on a 5x4 image.
// Windows are collected on handshake and compared to a reference list.
module tb_conv_window_gen_3x3;
    import conv_pkg::*;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    typedef int nine_t [9];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    conv_window_gen_3x3_if #(.DATA_WIDTH(6)) bus ();

    conv_window_gen_3x3 #(
        .DATA_WIDTH(6),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [5:0]  stream [$];
    logic [53:0] got_w  [$];
    logic        got_l  [$];
    int          got_p  [$];
    logic [53:0] ref_w  [$];
    logic        ref_l  [$];
    int          ref_p  [$];
    int          pix_idx;
    int          prev_acc;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [53:0] pk(input nine_t v);
        logic [53:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) begin
            r = {r[47:0], 6'(v[k])};
        end
        return r;
    endfunction

    function automatic logic [53:0] cur_win();
        return {bus.win_data_0, bus.win_data_1, bus.win_data_2,
                bus.win_data_3, bus.win_data_4, bus.win_data_5,
                bus.win_data_6, bus.win_data_7, bus.win_data_8};
    endfunction

    task automatic build_ref(input int frames);
        nine_t v;
        ref_w.delete();
        ref_l.delete();
        ref_p.delete();
        for (int f = 0; f < frames; f++) begin
            for (int r = 2; r < H; r++) begin
                for (int c = 2; c < W; c++) begin
                    for (int k = 0; k < 9; k++) begin
                        v[k] = int'(stream[f*NPIX + (r-2+k/3)*W + c-2+k%3]);
                    end
                    ref_w.push_back(pk(v));
                    ref_l.push_back(r == H-1 && c == W-1);
                    ref_p.push_back(f*NPIX + r*W + c);
                end
            end
        end
    endtask

    task automatic clear_got();
        got_w.delete();
        got_l.delete();
        got_p.delete();
    endtask

    // vmode 1 inserts a bubble every other cycle; rmode 1 stalls 5 cycles.
    task automatic feed(input int vmode, input int rmode, input int stop_n);
        int          cyc;
        int          stalls;
        logic [53:0] snap;
        bit          v;
        cyc      = 0;
        stalls   = 0;
        snap     = '0;
        pix_idx  = 0;
        prev_acc = -1;
        forever begin
            @(negedge clk);
            if (pix_idx >= stop_n &&
                (stop_n < stream.size() || !bus.win_valid)) break;
            if (cyc >= 500) begin
                check("timeout", 1, 0);
                break;
            end
            v = (pix_idx < stop_n) && (vmode == 0 || cyc % 2 == 0);
            bus.in_valid  = v;
            bus.in_data   = v ? stream[pix_idx] : 6'd0;
            bus.win_ready = 1'b1;
            if (rmode == 1 && bus.win_valid && stalls < 5) begin
                if (stalls == 0) snap = cur_win();
                bus.win_ready = 1'b0;
                stalls++;
            end
            #1;
            if (!bus.win_ready) begin
                check("bp_in_ready", 64'(bus.in_ready), 0);
                check("bp_hold", 64'(cur_win()), 64'(snap));
            end
            if (bus.win_valid && bus.win_ready) begin
                got_w.push_back(cur_win());
                got_l.push_back(bus.win_last);
                got_p.push_back(prev_acc);
            end
            if (bus.in_valid && bus.in_ready) begin
                prev_acc = pix_idx;
                pix_idx++;
            end else begin
                prev_acc = -1;
            end
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.win_ready = 1'b1;
    endtask

    task automatic compare(input string tag, input bit chk_pix);
        check({tag, "_count"}, 64'(got_w.size()), 64'(ref_w.size()));
        for (int i = 0; i < ref_w.size() && i < got_w.size(); i++) begin
            check($sformatf("%s_win%0d", tag, i), 64'(got_w[i]), 64'(ref_w[i]));
            check($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(ref_l[i]));
            if (chk_pix) begin
                check($sformatf("%s_lat%0d", tag, i), 64'(got_p[i]), 64'(ref_p[i]));
            end
        end
    endtask

    task automatic load_ramp(input int frames);
        stream.delete();
        for (int i = 0; i < NPIX; i++) stream.push_back(6'(i));
        if (frames > 1) begin
            for (int i = 0; i < NPIX; i++) stream.push_back(6'(63 - i));
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.win_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus.win_valid), 0);
        check("rst_last", 64'(bus.win_last), 0);
        check("rst_data", 64'(cur_win()), 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 1);

        load_ramp(1);
        build_ref(1);
        clear_got();
        feed(0, 0, NPIX);
        compare("basic", 1);
        check("basic_first", 64'(got_w[0]),
              64'(pk('{0, 1, 2, 5, 6, 7, 10, 11, 12})));
        check("basic_lastw", 64'(got_w[got_w.size()-1]),
              64'(pk('{7, 8, 9, 12, 13, 14, 17, 18, 19})));

        clear_got();
        feed(0, 1, NPIX);
        compare("bp", 0);
        check("bp_second", 64'(got_w[1]),
              64'(pk('{1, 2, 3, 6, 7, 8, 11, 12, 13})));

        clear_got();
        feed(1, 0, NPIX);
        compare("bub", 1);

        load_ramp(2);
        build_ref(2);
        clear_got();
        feed(0, 0, 2 * NPIX);
        check("b2b_total", 64'(got_w.size()), 64'(2 * win_count(H, W)));
        compare("b2b", 1);
        check("b2b_f2_first", 64'(got_w[6]),
              64'(pk('{63, 62, 61, 58, 57, 56, 53, 52, 51})));

        load_ramp(1);
        build_ref(1);
        clear_got();
        feed(0, 0, 14);
        check("mid_pending", 64'(bus.win_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.win_valid), 0);
        check("mid_rst_data", 64'(cur_win()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_got();
        feed(0, 0, NPIX);
        compare("mid", 1);

        stream.delete();
        for (int i = 0; i < NPIX; i++) stream.push_back(6'd63);
        build_ref(1);
        clear_got();
        feed(0, 0, NPIX);
        compare("max", 1);
        check("max_word", 64'(got_w[0]), {10'd0, {54{1'b1}}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
